// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO return-address stack with a three-state push/pop sequencer
// and sticky overflow/underflow/conflict flags.
module stack_ctrl #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     conflict,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold;
  logic idle, do_push, do_pop, ov_set, un_set, cf_set;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign busy  = state != IDLE;
  always_comb begin
    idle     = state == IDLE;
    do_push  = idle && push && !pop && !full;
    do_pop   = idle && pop && !push && !empty;
    ov_set   = idle && push && !pop && full;
    un_set   = idle && pop && !push && empty;
    cf_set   = idle && push && pop;
    state_nx = do_push ? WRITE : do_pop ? READ : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      state     <= state_nx;
      valid     <= state == READ;
      if (state == WRITE) count <= count + 1'b1;
      else if (do_pop) count <= count - 1'b1;
      if (state == READ) dout <= mem[count[AW-1:0]];
      // a fresh error outranks a simultaneous clear
      overflow  <= ov_set | (overflow & ~clr_err);
      underflow <= un_set | (underflow & ~clr_err);
      conflict  <= cf_set | (conflict & ~clr_err);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) hold <= din;
    if (state == WRITE) mem[count[AW-1:0]] <= hold;
  end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed stimulus checked every cycle against a queue-based
// transaction model, plus hand-computed literal expectations.
module tb_stack_ctrl;
  localparam int W = 10, D = 16;
  logic clk = 0, reset = 0, push = 0, pop = 0, clr_err = 0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic valid, busy, full, empty, overflow, underflow, conflict;
  logic [4:0] count;
  int total = 0, bad = 0;
  bit chk_en = 0;
  logic [W-1:0] q[$];
  int pend = 0;
  logic [W-1:0] pend_val = '0, m_dout = '0;
  bit m_valid = 0, m_ov = 0, m_un = 0, m_cf = 0;

  stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
    .dout(dout), .valid(valid), .busy(busy), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .conflict(conflict), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset;
    q.delete();
    pend = 0;
    m_dout = '0;
    m_valid = 0;
    m_ov = 0;
    m_un = 0;
    m_cf = 0;
  endtask

  // one clock of the transaction model: an accepted op occupies one extra cycle
  task automatic model_step;
    int was;
    bit ov, un, cf;
    was = pend;
    pend = 0;
    ov = 0;
    un = 0;
    cf = 0;
    m_valid = 0;
    if (was == 1) q.push_back(pend_val);
    else if (was == 2) begin
      m_dout = pend_val;
      m_valid = 1;
    end else begin
      cf = push && pop;
      ov = push && !pop && q.size() == D;
      un = pop && !push && q.size() == 0;
      if (push && !pop && q.size() < D) begin
        pend = 1;
        pend_val = din;
      end else if (pop && !push && q.size() > 0) begin
        pend = 2;
        pend_val = q.pop_back();
      end
    end
    m_ov = ov | (m_ov & !clr_err);
    m_un = un | (m_un & !clr_err);
    m_cf = cf | (m_cf & !clr_err);
  endtask

  initial forever begin
    @(posedge clk);
    if (reset) model_step();
  end

  always @(negedge clk) if (chk_en) begin
    chk("m.dout", dout, m_dout);
    chk("m.valid", valid, m_valid);
    chk("m.busy", busy, pend != 0);
    chk("m.count", count, q.size());
    chk("m.full", full, q.size() == D);
    chk("m.empty", empty, q.size() == 0);
    chk("m.overflow", overflow, m_ov);
    chk("m.underflow", underflow, m_un);
    chk("m.conflict", conflict, m_cf);
  end

  task automatic do_push(input logic [W-1:0] v);
    din = v;
    push = 1;
    @(negedge clk);
    push = 0;
    @(negedge clk);
  endtask

  task automatic do_pop;
    pop = 1;
    @(negedge clk);
    pop = 0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    chk_en = 1;
    #3;
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.busy", busy, 0);
    chk("rst.dout", dout, 0);
    chk("rst.valid", valid, 0);
    #9 reset = 1;
    @(negedge clk);
    din = 10'h155; push = 1;
    @(negedge clk);
    chk("p1.busy", busy, 1);
    chk("p1.count", count, 0);
    push = 0;
    @(negedge clk);
    chk("p1.idle", busy, 0);
    chk("p1.count1", count, 1);
    pop = 1;
    @(negedge clk);
    chk("pop1.busy", busy, 1);
    chk("pop1.count", count, 0);
    pop = 0;
    @(negedge clk);
    chk("pop1.dout", dout, 10'h155);
    chk("pop1.valid", valid, 1);
    chk("pop1.empty", empty, 1);
    @(negedge clk);
    chk("pop1.pulse", valid, 0);
    for (int i = 1; i <= 16; i++) do_push(W'(i));
    chk("fill.full", full, 1);
    chk("fill.count", count, 16);
    do_push(10'h3ff);
    chk("ovf.flag", overflow, 1);
    chk("ovf.count", count, 16);
    for (int i = 16; i >= 1; i--) begin
      do_pop();
      chk("lifo.dout", dout, i);
      chk("lifo.valid", valid, 1);
    end
    chk("drain.empty", empty, 1);
    do_pop();
    chk("unf.flag", underflow, 1);
    chk("unf.valid", valid, 0);
    chk("unf.dout", dout, 1);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    chk("clr.underflow", underflow, 0);
    chk("clr.overflow", overflow, 0);
    do_push(10'h00a);
    do_push(10'h00b);
    do_push(10'h00c);
    push = 1; pop = 1; clr_err = 1;
    @(negedge clk);
    push = 0; pop = 0; clr_err = 0;
    chk("cf.flag", conflict, 1);
    chk("cf.count", count, 3);
    chk("cf.busy", busy, 0);
    @(negedge clk);
    chk("cf.valid", valid, 0);
    chk("cf.sticky", conflict, 1);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    chk("cf.clr", conflict, 0);
    din = 10'h2aa; push = 1;
    @(negedge clk);
    push = 0; pop = 1;
    @(negedge clk);
    chk("hold.count", count, 4);
    chk("hold.busy", busy, 0);
    @(negedge clk);
    chk("hold.popcnt", count, 3);
    chk("hold.popbusy", busy, 1);
    pop = 0;
    @(negedge clk);
    chk("hold.dout", dout, 10'h2aa);
    chk("hold.valid", valid, 1);
    do_push(10'h111);
    do_push(10'h222);
    chk("five.count", count, 5);
    pop = 1;
    @(negedge clk);
    pop = 0;
    chk("mid.busy", busy, 1);
    #2 reset = 0;
    model_reset();
    #1;
    chk("arst.count", count, 0);
    chk("arst.busy", busy, 0);
    chk("arst.valid", valid, 0);
    chk("arst.dout", dout, 0);
    #9 reset = 1;
    @(negedge clk);
    do_push(10'h077);
    do_pop();
    chk("resume.dout", dout, 10'h077);
    chk("resume.valid", valid, 1);
    chk("resume.count", count, 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 10: width of the return-address entry (matches the PC width).
REQ-002 The block SHALL provide parameter DEPTH, default 16: number of stack entries (power of two).
REQ-003 The block SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL provide port push, input, 1: push request, sampled only in IDLE.
REQ-006 The block SHALL provide port pop, input, 1: pop request, sampled only in IDLE.
REQ-007 The block SHALL provide port din, input, WIDTH: value to push, captured in the accept cycle.
REQ-008 The block SHALL provide port clr_err, input, 1: synchronous clear of the sticky error flags.
REQ-009 The block SHALL provide port dout, output, WIDTH: registered popped value.
REQ-010 The block SHALL provide port valid, output, 1: one-cycle pulse when dout is updated by a pop.
REQ-011 The block SHALL provide port busy, output, 1: high while a push or pop is in progress.
REQ-012 The block SHALL provide ports full and empty, output, 1 each: high for count==DEPTH and count==0 respectively.
REQ-013 The block SHALL provide ports overflow, underflow and conflict, output, 1 each: sticky error flags.
REQ-014 The block SHALL provide port count, output, log2(DEPTH)+1: current number of stored entries.

Function
REQ-015 Storage SHALL be an internal DEPTH x WIDTH register array addressed by a stack pointer sp equal to count.
REQ-016 The FSM SHALL have exactly three states: IDLE, WRITE and READ.
REQ-017 In IDLE, for push=1, pop=0 and not full, the block SHALL latch din and go to WRITE.
REQ-018 In WRITE, the block SHALL write the latched value to mem[sp], increment count and return to IDLE, giving a 2-cycle push.
REQ-019 In IDLE, for pop=1, push=0 and not empty, the block SHALL decrement count and go to READ.
REQ-020 In READ, the block SHALL load dout from mem[new sp], pulse valid for that single clock edge and return to IDLE, so dout/valid appear 2 cycles after the pop is accepted.
REQ-021 busy SHALL be high in WRITE and READ and low in IDLE.
REQ-022 push or pop asserted outside IDLE SHALL be ignored with no flag change; the requester SHALL hold the request until busy is low.
REQ-023 A push while full in IDLE SHALL set overflow, leave count, the memory and the state unchanged, and keep the FSM in IDLE.
REQ-024 A pop while empty in IDLE SHALL set underflow, leave dout unchanged, produce no valid pulse, and keep the FSM in IDLE.
REQ-025 push=1 and pop=1 together in IDLE SHALL set conflict and perform no operation.
REQ-026 The error flags SHALL stay set until clr_err=1.
REQ-027 If clr_err and a new error occur in the same cycle, the new error SHALL win and the flag SHALL read 1.
REQ-028 count SHALL never exceed DEPTH or go below 0; there SHALL be no wrap-around.
REQ-029 dout SHALL change only in READ.

Reset
REQ-030 With reset=0, asynchronously: state=IDLE; count=0; dout=0; valid=0; busy=0; overflow=underflow=conflict=0; empty=1; full=0.
REQ-031 Memory contents SHALL NOT be required to reset.
REQ-032 A reset during WRITE or READ SHALL abort the operation, with count=0 afterwards.
REQ-033 Operation SHALL resume on the first rising clk edge after reset deasserts.

Verification
REQ-034 Push 0x155 then pop -> busy high for 1 cycle after each accept; dout=0x155 with valid pulse 2 cycles after the pop accept; count returns 1->0; empty=1.
REQ-035 Push 0x001..0x010 (16 pushes), then a 17th push -> full=1, count=16, overflow=1; 16 pops return 0x010 down to 0x001 in LIFO order.
REQ-036 Pop when empty -> underflow=1, no valid pulse, dout holds its last value; clr_err=1 for one cycle -> underflow=0.
REQ-037 push=pop=1 in IDLE with count=3 -> conflict=1, count stays 3, no valid pulse.
REQ-038 Push accepted, then pop asserted during WRITE -> the pop is ignored, count=1, and the pop is accepted once held into IDLE.
REQ-039 reset=0 asserted mid-READ with count=5 -> count=0, busy=0, valid=0 immediately, without waiting for a clk edge.
